// File: rtl/hub75_rx.sv
// HUB75 panel receiver: synchronizes the panel bus, collects one shifted row pair,
// commits it on LAT/OE into a 32-row frame buffer and serves registered pixel reads.
module hub75_rx #(
    parameter int COLS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_shft,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       R0,
    input  logic       G0,
    input  logic       B0,
    input  logic       R1,
    input  logic       G1,
    input  logic       B1,
    input  logic       LAT,
    input  logic       OE,
    input  logic [4:0] rd_row,
    input  logic [5:0] rd_col,
    output logic [2:0] rd_rgb,
    output logic       row_wr,
    output logic [3:0] row_addr,
    output logic       frame_done,
    output logic [7:0] err_cnt
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = $clog2(COLS + 1);
    localparam logic [CNT_W-1:0] COLS_V = CNT_W'(COLS);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] READY   = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;

    logic [12:0] sync1, sync2;
    logic [2:0]  prev;
    logic [1:0]  state, state_n;
    logic [CNT_W-1:0] bit_cnt, cnt_n;
    logic [COLS-1:0][2:0] shift_up, shift_lo, up_n, lo_n;
    logic [COLS-1:0][2:0] hold_up, hold_lo;
    logic [3:0]  hold_addr;
    logic [COLS-1:0][2:0] frame [32];

    logic       shift_rise, lat_rise, oe_fall, lat_ok;
    logic [3:0] s_addr;
    logic [2:0] s_up, s_lo;

    assign shift_rise = sync2[12] & ~prev[2];
    assign lat_rise   = sync2[11] & ~prev[1];
    assign oe_fall    = ~sync2[10] & prev[0];
    assign s_addr     = sync2[9:6];
    assign s_up       = sync2[5:3];
    assign s_lo       = sync2[2:0];

    // The shift in this cycle is folded in before the latch looks at the count.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned; a missed branch would otherwise infer a latch.
        up_n  = shift_up;
        lo_n  = shift_lo;
        cnt_n = bit_cnt;
        if (shift_rise && bit_cnt < COLS_V) begin
            up_n[bit_cnt[COL_W-1:0]] = s_up;
            lo_n[bit_cnt[COL_W-1:0]] = s_lo;
            cnt_n = bit_cnt + CNT_W'(1);
        end
        lat_ok = lat_rise && (cnt_n == COLS_V);
    end

    always_comb begin
        state_n = state;
        case (state)
            COLLECT: if (lat_ok) state_n = READY;
            READY:   if (oe_fall) state_n = WRITE;
            WRITE:   state_n = lat_ok ? READY : COLLECT;
            default: state_n = COLLECT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            state     <= COLLECT;
            bit_cnt   <= '0;
            shift_up  <= '0;
            shift_lo  <= '0;
            hold_up   <= '0;
            hold_lo   <= '0;
            hold_addr <= '0;
            err_cnt   <= '0;
        end else begin
            sync1   <= {clk_shft, LAT, OE, D, C, B, A, R0, G0, B0, R1, G1, B1};
            sync2   <= sync1;
            prev    <= sync2[12:10];
            state   <= state_n;
            shift_up <= up_n;
            shift_lo <= lo_n;
            bit_cnt  <= lat_rise ? '0 : cnt_n;
            if (lat_ok) begin
                hold_up   <= up_n;
                hold_lo   <= lo_n;
                hold_addr <= s_addr;
            end else if (lat_rise && err_cnt != 8'hff) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // A LAT accepted during WRITE reloads the hold registers only after this write
    // has taken the old contents, so the latch is kept for the next commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the frame buffer is built from flops, not a RAM macro, because the
            // whole image must read back as zero straight after reset.
            for (int r = 0; r < 32; r++) frame[r] <= '0;
            row_wr     <= 1'b0;
            row_addr   <= '0;
            frame_done <= 1'b0;
            rd_rgb     <= '0;
        end else begin
            row_wr     <= 1'b0;
            frame_done <= 1'b0;
            if (state == WRITE) begin
                frame[{1'b0, hold_addr}] <= hold_up;
                frame[{1'b1, hold_addr}] <= hold_lo;
                row_wr     <= 1'b1;
                row_addr   <= hold_addr;
                frame_done <= (hold_addr == 4'd15);
            end
            rd_rgb <= (int'(rd_col) < COLS) ? frame[rd_row][rd_col] : 3'b000;
        end
    end

endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 Parameter COLS, default 64, meaning pixels per shifted row (one value per data lane).
REQ-002 Port clk  input  1  system clock; all logic on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset.
REQ-004 Port clk_shft  input  1  panel shift clock, asynchronous to clk.
REQ-005 Port A, B, C, D  input  1 each  row-pair address, D = MSB.
REQ-006 Port R0, G0, B0  input  1 each  upper-half serial pixel data.
REQ-007 Port R1, G1, B1  input  1 each  lower-half serial pixel data.
REQ-008 Port LAT  input  1  latch strobe; its rising edge ends a row.
REQ-009 Port OE  input  1  output enable, active-low; its falling edge commits the row.
REQ-010 Port rd_row  input  5  frame-buffer read row, 0-31.
REQ-011 Port rd_col  input  6  frame-buffer read column.
REQ-012 Port rd_rgb  output  3  read pixel {R,G,B}, registered.
REQ-013 Port row_wr  output  1  one-cycle pulse when a row pair is committed.
REQ-014 Port row_addr  output  4  address of the last committed row pair.
REQ-015 Port frame_done  output  1  one-cycle pulse when row pair 15 is committed.
REQ-016 Port err_cnt  output  8  saturating count of malformed latches.

Function
REQ-017 All panel inputs SHALL pass as one group through a 2-flop synchronizer; edges SHALL be detected on the synchronized copies.
REQ-018 Panel timing SHALL be: clk_shft high >= 2 clk, clk_shft low >= 2 clk, data and address stable across the clk_shft rising edge. Behaviour outside these limits is not required.
REQ-019 Each clk_shft rising edge SHALL capture six data bits into column bit_cnt, then increment bit_cnt.
- First pixel shifted = column 0.
- When bit_cnt >= COLS, the data SHALL be discarded and bit_cnt SHALL saturate at COLS.
REQ-020 The FSM SHALL have three states: COLLECT, READY and WRITE. Reset state is COLLECT.
REQ-021 On a LAT rising edge with bit_cnt == COLS, the block SHALL copy the shift data and {D,C,B,A} into hold registers, then go to READY.
- This applies from COLLECT and from READY; in READY the hold registers are overwritten.
REQ-022 On a LAT rising edge with bit_cnt != COLS, err_cnt SHALL increment (saturating at 255), the hold registers SHALL be unchanged and the state SHALL be unchanged.
REQ-023 Every LAT rising edge SHALL clear bit_cnt to 0.
REQ-024 If a clk_shft edge and a LAT edge are detected in the same cycle, the shift SHALL be counted first, then the latch SHALL be evaluated.
REQ-025 An OE falling edge in READY SHALL move the FSM to WRITE for exactly one cycle. In that cycle:
- upper data is written to frame row addr;
- lower data is written to frame row addr+16;
- row_wr and row_addr update;
- frame_done pulses if addr == 15.
After that cycle the FSM returns to COLLECT.
REQ-026 An OE falling edge in COLLECT SHALL be ignored.
REQ-027 Shift edges SHALL keep accumulating during READY and WRITE.
REQ-028 A LAT edge during WRITE SHALL be evaluated after the write completes, and SHALL not be lost.
REQ-029 rd_rgb SHALL show frame[rd_row][rd_col] one clk after the address is presented.
REQ-030 rd_rgb SHALL be 0 when rd_col >= COLS.
REQ-031 A read and a write to the same pixel in the same cycle SHALL return the old value.

Reset
REQ-032 While rst = 0, the block SHALL asynchronously clear:
- rd_rgb, row_wr, row_addr, frame_done, err_cnt, bit_cnt;
- the hold registers and synchronizers;
- the whole frame buffer.
The FSM SHALL be forced to COLLECT.
REQ-033 Reset asserted mid-row SHALL discard any partial shift data. After release, the first valid row SHALL need a full COLS shifts plus a LAT.

Verification
REQ-034 64 shifts with upper = column mod 2 (R only) and lower = all B; address 3; LAT; OE low -> one row_wr pulse, row_addr = 3.
- Row 3: R at odd columns only.
- Row 19: rgb = 001 at every column.
REQ-035 63 shifts, then LAT -> err_cnt = 1 and no row_wr. A following OE fall -> no write.
REQ-036 Rows 0-15 each driven with a full row + LAT + OE -> 16 row_wr pulses, and frame_done pulses only with row_addr = 15.
REQ-037 70 shifts then LAT -> accepted as a valid row, and columns 0-63 hold the first 64 pixels.
REQ-038 Reset pulsed after 30 shifts, then 34 shifts + LAT -> err_cnt = 1; frame buffer reads return 0.
REQ-039 Last clk_shft edge and LAT edge in the same synchronized cycle -> the row is accepted, err_cnt unchanged.
